// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I immediate encoder: format select codes,
// the opcodes/funct3 used by the LI pseudo-instruction expansion, the FSM
// state type and a sign-extension legality helper.
// Optional feature macro: IMM_ENCODER_LI_EXPAND_EN (adds the LI_LO state).
package rv32i_pkg;

  // imm_select encodings
  localparam logic [2:0] SEL_I    = 3'b000;
  localparam logic [2:0] SEL_S    = 3'b001;
  localparam logic [2:0] SEL_B    = 3'b010;
  localparam logic [2:0] SEL_J    = 3'b011;
  localparam logic [2:0] SEL_U    = 3'b100;
  localparam logic [2:0] SEL_LI   = 3'b101;
  localparam logic [2:0] SEL_RSVD = 3'b110;
  localparam logic [2:0] SEL_R    = 3'b111;

  // Opcodes / funct3 emitted by the LI expansion
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_OP_IMM  = 7'b0010011;
  localparam logic [2:0] FUNCT3_ADDI = 3'b000;

  // Encoder FSM state. LI_LO only exists when LI expansion is built in.
`ifdef IMM_ENCODER_LI_EXPAND_EN
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_LI_LO = 1'b1
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0
  } state_t;
`endif

  // True when every bit of v at or above sign_bit equals v[sign_bit],
  // i.e. v is the sign extension of its low (sign_bit+1) bits.
  function automatic logic is_sext(input logic [31:0] v, input logic [4:0] sign_bit);
    logic [31:0] m;
    m = ~((32'd1 << sign_bit) - 32'd1);
    return ((v & m) == 32'd0) || ((v & m) == m);
  endfunction

endpackage

// File: rtl/rv32i_imm_pack.sv
// Combinational RV32I format scatter plus immediate legality check.
// Select codes outside I/S/B/J/U/R (LI and reserved) produce an all-zero
// word with the error flag set; the error for reserved codes is not gated
// by RANGE_CHECK.
module rv32i_imm_pack
  import rv32i_pkg::*;
#(
  parameter int unsigned RANGE_CHECK = 1
) (
  input  logic [2:0]  i_sel,
  input  logic [6:0]  i_opcode,
  input  logic [2:0]  i_funct3,
  input  logic [6:0]  i_funct7,
  input  logic [4:0]  i_rd,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [31:0] i_imm,
  output logic [31:0] o_word,
  output logic        o_err
);

  logic [31:0] w_word;
  logic        w_bad;
  logic        w_rsvd;

  // Scatter the immediate and register fields for the selected format
  always_comb begin
    w_word = 32'd0;
    w_bad  = 1'b0;
    w_rsvd = 1'b0;
    case (i_sel)
      SEL_I: begin
        w_word = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        w_bad  = !is_sext(i_imm, 5'd11);
      end
      SEL_S: begin
        w_word = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        w_bad  = !is_sext(i_imm, 5'd11);
      end
      SEL_B: begin
        w_word = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                  i_imm[4:1], i_imm[11], i_opcode};
        w_bad  = i_imm[0] || !is_sext(i_imm, 5'd12);
      end
      SEL_J: begin
        w_word = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        w_bad  = i_imm[0] || !is_sext(i_imm, 5'd20);
      end
      SEL_U: begin
        w_word = {i_imm[31:12], i_rd, i_opcode};
        w_bad  = (i_imm[11:0] != 12'd0);
      end
      SEL_R: begin
        w_word = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
      end
      SEL_LI, SEL_RSVD: begin
        w_rsvd = 1'b1;
      end
      default: begin
        w_rsvd = 1'b1;
      end
    endcase
  end

  assign o_word = w_word;
  assign o_err  = w_rsvd || ((RANGE_CHECK != 0) && w_bad);

endmodule

// File: rtl/rv32i_imm_encoder.sv
// RV32I instruction encoder: accepts one request per handshake and emits
// one registered instruction beat (two for an LI that needs LUI+ADDI).
// Optional feature macro: IMM_ENCODER_LI_EXPAND_EN. When undefined, LI
// (imm_select 101) is handled as a reserved select.
//
// Handshakes: a request transfers when in_valid && in_ready at a rising
// clk edge; a beat transfers when out_valid && out_ready at a rising edge.
// While out_valid is high and out_ready is low the beat holds stable.
module rv32i_imm_encoder
  import rv32i_pkg::*;
#(
  parameter int unsigned RANGE_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  imm_select,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instruction,
  output logic        out_last,
  output logic        range_err,
  output state_t      dbg_state
);

  state_t      r_state;
  state_t      w_nxt_state;
  logic        r_out_valid;
  logic        w_nxt_valid;
  logic [31:0] r_instr;
  logic [31:0] w_nxt_instr;
  logic        r_last;
  logic        w_nxt_last;
  logic        r_err;
  logic        w_nxt_err;

  // Inputs presented to the format packer (remapped for LI)
  logic [2:0]  w_p_sel;
  logic [6:0]  w_p_opcode;
  logic [2:0]  w_p_funct3;
  logic [4:0]  w_p_rs1;
  logic [31:0] w_p_imm;
  logic [31:0] w_p_word;
  logic        w_p_err;
  logic        w_first_last;

  logic        w_accept;
  logic        w_out_xfer;

`ifdef IMM_ENCODER_LI_EXPAND_EN
  logic [31:0] r_lo_word;
  logic [31:0] w_nxt_lo_word;
  logic [31:0] w_li_sum;
  logic [31:0] w_lo_word;
  logic        w_li_fits;

  // Rounding the upper part by +0x800 compensates for ADDI sign-extending
  // the low 12 bits; wraps modulo 2^32.
  assign w_li_sum  = imm + 32'h0000_0800;
  assign w_li_fits = is_sext(imm, 5'd11);
  assign w_lo_word = {imm[11:0], rd, FUNCT3_ADDI, rd, OPC_OP_IMM};
`endif

  assign in_ready   = !rst && (r_state == ST_IDLE) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Route the request into the packer; LI is rewritten as ADDI or LUI
  always_comb begin
    w_p_sel      = imm_select;
    w_p_opcode   = opcode;
    w_p_funct3   = funct3;
    w_p_rs1      = rs1;
    w_p_imm      = imm;
    w_first_last = 1'b1;
`ifdef IMM_ENCODER_LI_EXPAND_EN
    if (imm_select == SEL_LI) begin
      if (w_li_fits) begin
        w_p_sel    = SEL_I;
        w_p_opcode = OPC_OP_IMM;
        w_p_funct3 = FUNCT3_ADDI;
        w_p_rs1    = 5'd0;
      end else begin
        w_p_sel      = SEL_U;
        w_p_opcode   = OPC_LUI;
        w_p_imm      = {w_li_sum[31:12], 12'd0};
        w_first_last = (imm[11:0] == 12'd0);
      end
    end
`endif
  end

  rv32i_imm_pack #(
    .RANGE_CHECK (RANGE_CHECK)
  ) u_pack (
    .i_sel    (w_p_sel),
    .i_opcode (w_p_opcode),
    .i_funct3 (w_p_funct3),
    .i_funct7 (funct7),
    .i_rd     (rd),
    .i_rs1    (w_p_rs1),
    .i_rs2    (rs2),
    .i_imm    (w_p_imm),
    .o_word   (w_p_word),
    .o_err    (w_p_err)
  );

  // Next-state and next output beat: accept loads a new beat, a transfer
  // either advances LI to its ADDI beat or empties the output register
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_valid = r_out_valid;
    w_nxt_instr = r_instr;
    w_nxt_last  = r_last;
    w_nxt_err   = r_err;
`ifdef IMM_ENCODER_LI_EXPAND_EN
    w_nxt_lo_word = r_lo_word;
`endif
    if (w_accept) begin
      w_nxt_valid = 1'b1;
      w_nxt_instr = w_p_word;
      w_nxt_last  = w_first_last;
      w_nxt_err   = w_p_err;
`ifdef IMM_ENCODER_LI_EXPAND_EN
      w_nxt_lo_word = w_lo_word;
      if (!w_first_last) begin
        w_nxt_state = ST_LI_LO;
      end
`endif
    end else if (w_out_xfer) begin
`ifdef IMM_ENCODER_LI_EXPAND_EN
      if (r_state == ST_LI_LO) begin
        w_nxt_instr = r_lo_word;
        w_nxt_last  = 1'b1;
        w_nxt_err   = 1'b0;
        w_nxt_state = ST_IDLE;
      end else begin
        w_nxt_valid = 1'b0;
      end
`else
      w_nxt_valid = 1'b0;
`endif
    end
  end

  // State and output beat registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_instr     <= 32'd0;
      r_last      <= 1'b0;
      r_err       <= 1'b0;
`ifdef IMM_ENCODER_LI_EXPAND_EN
      r_lo_word   <= 32'd0;
`endif
    end else begin
      r_state     <= w_nxt_state;
      r_out_valid <= w_nxt_valid;
      r_instr     <= w_nxt_instr;
      r_last      <= w_nxt_last;
      r_err       <= w_nxt_err;
`ifdef IMM_ENCODER_LI_EXPAND_EN
      r_lo_word   <= w_nxt_lo_word;
`endif
    end
  end

  assign out_valid   = r_out_valid;
  assign instruction = r_instr;
  assign out_last    = r_last;
  assign range_err   = r_err;
  assign dbg_state   = r_state;

endmodule

// File: doc/rv32i_imm_encoder.md
RV32I_IMM_ENCODER -- requirements
Module: rv32i_imm_encoder

Interface
REQ-001 Parameter RANGE_CHECK, default 1: 1 = range_err driven by immediate legality checks; 0 = range_err tied 0.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  request present; in_ready  out  1  request accepted when both high at a clk edge.
REQ-005 imm_select  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 LI pseudo, 110 reserved, 111 R-type (no immediate).
REQ-006 opcode  in  7, funct3  in  3, funct7  in  7, rd  in  5, rs1  in  5, rs2  in  5: instruction fields, placed at standard RV32I positions for the selected format.
REQ-007 imm  in  32  byte-offset/constant value to scatter into the instruction.
REQ-008 out_valid  out  1, out_ready  in  1: output beat handshake; transfer when both high at a clk edge.
REQ-009 instruction  out  32  encoded word; out_last  out  1  final beat of a request; range_err  out  1  immediate illegal for the format.

Function
REQ-010 Scatter: I imm[11:0]->[31:20]; S imm[11:5]->[31:25], imm[4:0]->[11:7]; B imm[12]->[31], imm[10:5]->[30:25], imm[4:1]->[11:8], imm[11]->[7]; J imm[20]->[31], imm[10:1]->[30:21], imm[11]->[20], imm[19:12]->[19:12]; U imm[31:12]->[31:12].
REQ-011 Range: I/S imm must be sign-extension of imm[11]; B imm[0]=0 and sign-extension of imm[12]; J imm[0]=0 and sign-extension of imm[20]; U imm[11:0]=0; R never errors; violation sets range_err on that beat, truncated word still emitted.
REQ-012 Latency: request accepted at edge N presents its first beat with out_valid=1 after edge N; beat registered, no combinational in->out path.
REQ-013 in_ready = (state==IDLE) and (out_valid==0 or out_ready==1); low while rst high.
REQ-014 While out_valid=1 and out_ready=0, instruction, out_last, range_err hold stable.
REQ-015 FSM states IDLE, LI_LO; all non-LI requests: single beat, out_last=1, remain IDLE.
REQ-016 LI, imm fits signed 12-bit: single beat ADDI rd,x0,imm[11:0] (opcode 0010011, funct3 000), out_last=1, stay IDLE.
REQ-017 LI otherwise: hi=(imm+0x800)[31:12], modulo 2^32 wrap; beat 1 LUI rd,hi (opcode 0110111), out_last=0, go LI_LO; on beat-1 transfer emit ADDI rd,rd,imm[11:0], out_last=1, return IDLE.
REQ-018 LI with imm[11:0]=0 and not fitting 12 bits: LUI only, out_last=1, stay IDLE.
REQ-019 LI ignores opcode/funct3/funct7/rs1/rs2 inputs; rd=0 still encoded.
REQ-020 Reserved 110: instruction=0x00000000, out_last=1, range_err=1 regardless of RANGE_CHECK.
REQ-021 Output transfer and new acceptance in the same cycle supported (back-to-back single-beat throughput 1/cycle).

Reset
REQ-022 During rst: state=IDLE, out_valid=0, instruction=0x00000000, out_last=0, range_err=0, in_ready=0.
REQ-023 rst in LI_LO discards the pending second beat; none emitted after rst deasserts.
REQ-024 First acceptance possible at the first edge with rst low.

Configuration
REQ-025 Macro IMM_ENCODER_LI_EXPAND_EN defined: imm_select 101 behaves per REQ-016..REQ-019.
REQ-026 Macro undefined: LI_LO state absent; 101 treated as reserved per REQ-020.

Structure
REQ-027 Shared package rv32i_pkg holds imm_select encodings, OPC_LUI, OPC_OP_IMM, FUNCT3_ADDI and the FSM state enum.
REQ-028 Sub-module rv32i_imm_pack: combinational format scatter plus range check, instantiated once.

Verification
REQ-029 I: sel 000, opcode 0010011, funct3 0, rd 5, rs1 6, imm 0xFFFFFFFF -> 0xFFF30293, out_last 1, range_err 0, one cycle after accept.
REQ-030 B: sel 010, opcode 1100011, rs1 1, rs2 2, imm 8 -> 0x00208463, range_err 0; imm 7 -> range_err 1.
REQ-031 LI: rd 10, imm 0x12345678 -> 0x12345537 (out_last 0) then 0x67850513 (out_last 1); imm 0x7FFFF800 -> 0x80000537 then 0x80050513.
REQ-032 Backpressure: out_ready low 3 cycles during LI beat 1 -> word stable, in_ready 0, beat 2 only after beat-1 transfer.
REQ-033 rst asserted in LI_LO -> out_valid 0 next cycle, no ADDI beat afterward; without IMM_ENCODER_LI_EXPAND_EN, sel 101 -> 0x00000000, range_err 1.
